// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fir_state_t;

  localparam int FIR_SIZE_DEFAULT = 64;

endpackage

// File: rtl/fir_tap_counter.sv
// Tap index counter: synchronous clear, count enable, terminal-count flag at
// FIR_size-1 and wrap to 0, so the index never leaves 0..FIR_size-1.
module fir_tap_counter
  import fir_pkg::*;
#(
  parameter int FIR_size = FIR_SIZE_DEFAULT,
  parameter int ADDR_W   = $clog2(FIR_size)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FIR_size - 1);

  logic [ADDR_W-1:0] r_count;

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST);

  // Count up while enabled; wrap explicitly at the last tap for non power-of-2 sizes.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_tc ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fir_controller.sv
// Sequencer for a serial multiply-accumulate FIR datapath.
// Optional feature: define FIR_CTRL_OVERRUN_EN to build the sticky overrun flag;
// otherwise overrun is tied low and no flag register exists.
//
// state | meaning
// IDLE  | waiting for first sample, datapath flushed
// CALC  | stepping tap address 0..FIR_size-1
// DRAIN | last product enters accumulator
// DONE  | result final on dout, ready for next sample
module fir_controller
  import fir_pkg::*;
#(
  parameter  int FIR_size     = FIR_SIZE_DEFAULT,
  localparam int address_size = $clog2(FIR_size)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    shift,
  output logic                    flush,
  output logic                    freeze,
  output logic [address_size-1:0] address,
  output logic                    out_valid,
  output logic                    overrun
);

  fir_state_t              r_state;
  fir_state_t              w_state_next;
  logic                    w_cnt_clear;
  logic                    w_cnt_en;
  logic                    w_cnt_tc;
  logic [address_size-1:0] w_count;

  fir_tap_counter #(
    .FIR_size (FIR_size),
    .ADDR_W   (address_size)
  ) u_tap_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_en),
    .o_count  (w_count),
    .o_tc     (w_cnt_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode; rst forces the safe flushed/frozen outputs.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    in_ready     = 1'b0;
    shift        = 1'b0;
    flush        = 1'b0;
    freeze       = 1'b0;
    address      = '0;
    out_valid    = 1'b0;
    if (rst) begin
      flush  = 1'b1;
      freeze = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          in_ready = 1'b1;
          flush    = 1'b1;
          freeze   = 1'b1;
          shift    = in_valid;
          if (in_valid) begin
            w_state_next = CALC;
            w_cnt_clear  = 1'b1;
          end
        end
        CALC: begin
          address  = w_count;
          w_cnt_en = 1'b1;
          if (w_cnt_tc) begin
            w_state_next = DRAIN;
          end
        end
        DRAIN: begin
          freeze       = 1'b1;
          w_state_next = DONE;
        end
        DONE: begin
          out_valid = 1'b1;
          freeze    = 1'b1;
          in_ready  = 1'b1;
          shift     = in_valid;
          flush     = in_valid;
          if (in_valid) begin
            w_state_next = CALC;
            w_cnt_clear  = 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

`ifdef FIR_CTRL_OVERRUN_EN
  logic r_overrun;

  // Sticky flag: a sample was offered while the sequencer was busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (in_valid && !in_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule
